intra_4x4_mode_ctx: RTL
=======================

# intra_4x4_mode_ctx

Intra 4x4 mode context manager and mode-syntax generator. It collects the 16 chosen intra4x4 modes of each macroblock in decoding (zig-zag 8x8/4x4) order. It maintains the current mode matrix, the left-column register and the top-row line buffer, and drives these to the existing `intra_4x4_pred_mode_gen` instance. It receives `mode_pred` back and emits `prev_intra4x4_pred_mode_flag` / `rem_intra4x4_pred_mode` to the entropy coder.

## Interface
- `MB_X_W`, 8: width of `mb_x`; must be ≥ `PIC_W_MB_LEN`.
- `MB_Y_W`, 8: width of `mb_y`; must be ≥ `PIC_H_MB_LEN`.
- `MAX_MB_X`, 120: number of top-line buffer entries (picture width in MBs).
- `clk` in 1: clock. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `mb_start` in 1: MB start pulse. Accepted only when `mb_rdy`=1.
- `mb_rdy` out 1: high in IDLE.
- `mb_i4x4` in 1: MB is I4x4, sampled with `mb_start`.
- `mb_x_in` in MB_X_W: MB column, sampled with `mb_start`.
- `mb_y_in` in MB_Y_W: MB row, sampled with `mb_start`.
- `mode_valid` in 1: best-mode handshake, valid.
- `mode_ready` out 1: best-mode handshake, ready.
- `mode_in` in 4: chosen mode (0..8) of the current block.
- `pg_mb_x` out MB_X_W: latched MB column, to the pred gen.
- `pg_mb_y` out MB_Y_W: latched MB row, to the pred gen.
- `pg_blk4x4_num` out 4: current block index, to the pred gen.
- `pg_bm_c` out 64: current mode matrix; nibble[63:60] = block 0.
- `pg_bm_l` out 16: left modes; [15:12] = row 0.
- `pg_bm_t` out 16: top modes; [15:12] = column 0.
- `pg_mode_pred` in 4: predicted mode from the pred gen (combinational return).
- `syn_valid` out 1: syntax output handshake, valid.
- `syn_ready` in 1: syntax output handshake, ready.
- `syn_blk` out 4: block index of the syntax element.
- `syn_flag` out 1: `prev_intra4x4_pred_mode_flag`.
- `syn_rem` out 3: `rem_intra4x4_pred_mode`.
- `mb_done` out 1: one-cycle pulse at MB completion.
- `err` out 1: sticky illegal-mode flag.

## Operation
- FSM states: IDLE, LOAD, RUN, WB.
- **IDLE**:
  - On `mb_start`: latch x, y and `mb_i4x4`; clear the matrix to 0; issue the top-buffer read at `mb_x_in`; go to LOAD.
- **LOAD** (one cycle):
  - Capture the read data into `pg_bm_t`.
  - Clear the block counter `blk` to 0.
  - Go to RUN if `mb_i4x4`, else go to WB.
- **RUN**:
  - `mode_ready` = !`syn_valid` || `syn_ready`.
  - `pg_blk4x4_num` = `blk`.
  - On a mode transfer:
    - Write `mode_in` into matrix nibble `blk`.
    - Register `syn_blk`=`blk`.
    - `syn_flag` = (`mode_in` == `pg_mode_pred`).
    - `syn_rem` = `mode_in` < `pg_mode_pred` ? `mode_in`[2:0] : (`mode_in`−1)[2:0].
    - Set `syn_valid`.
    - Increment `blk`.
  - After the transfer at `blk`=15, go to WB.
- **WB** (one cycle):
  - Top buffer[x] ← {m10, m11, m14, m15}.
  - Left register ← {m5, m7, m13, m15}.
  - For a non-I4x4 MB, both are written as {2, 2, 2, 2} (DC substitution) and no syntax is emitted.
  - Pulse `mb_done`, go to IDLE.
- Output register: `syn_valid` clears on `syn_valid` && `syn_ready` without a new transfer. A new transfer in the same cycle reloads it.
- Boundaries:
  - `mb_x`=0 and `mb_y`=0 masking stays in the pred gen; the left register and top buffer are passed through unmodified.
  - `mb_start` outside IDLE is ignored.
  - `mode_valid` outside RUN is ignored, and `mode_ready`=0.
  - x ≥ `MAX_MB_X`: the write is suppressed and the read returns 16'h2222.

## Timing
- Reset values:
  - FSM=IDLE, `mb_rdy`=1, `mode_ready`=0.
  - `syn_valid`=0, `syn_blk`=0, `syn_flag`=0, `syn_rem`=0.
  - `mb_done`=0, `err`=0.
  - `pg_*` registers = 0, left register = 16'h2222.
  - The top buffer is not reset; the pred gen masks row 0.
- Latency:
  - `mb_start` → first `mode_ready` in 2 cycles.
  - Mode transfer → `syn_valid` in 1 cycle.
  - Last transfer → `mb_done` in 1 cycle (WB).
- Throughput: one block per cycle with `syn_ready`=1. An I4x4 MB takes 19 cycles from start to `mb_done`.
- `rst_n` deassertion mid-MB returns to IDLE and discards the partial MB.

## Configuration
- `INTRA4X4_MODE_CHK_EN` defined:
  - `mode_in` > 8 is replaced by 2 before storage and syntax generation.
  - `err` is set and holds until reset.
- Undefined: `mode_in` is used unmodified, and `err` is tied 0.

## Structure
- Shared package constants:
  - `I4_MODE_DC`=2 and `I4_MODE_NA`=15.
  - Right-column index set {5, 7, 13, 15}.
  - Bottom-row index set {10, 11, 14, 15}.
  - FSM state encodings.
- Sub-module `intra_4x4_top_line_buf`: `MAX_MB_X`×16 single-port synchronous RAM with 1-cycle read latency, write-enable and out-of-range guard.

## Test plan
- I4x4 MB at (1,1), left=16'h0000, top=16'h1111, modes all 0, pred gen returning 0 → 16 syntax outputs with `flag`=1, then `mb_done`; top[1]=16'h0000, left=16'h0000.
- `mode_in`=7 with `pg_mode_pred`=3 → `flag`=0, `rem`=6; `mode_in`=1 with `pred`=3 → `rem`=1.
- Non-I4x4 MB at x=2 → no `syn_valid`, `mb_done` 2 cycles after LOAD, top[2]=16'h2222, left=16'h2222.
- Hold `syn_ready`=0 for 5 cycles after the first output → `mode_ready`=0 throughout, `syn_blk`=0 held, no mode lost; resumes at `blk`=1.
- Assert `rst_n`=0 at `blk`=9 → all outputs at reset values; the next MB starts at `blk`=0.
- With `INTRA4X4_MODE_CHK_EN`, `mode_in`=12 → stored nibble=2, `err`=1 sticky.

Source files
------------

// File: rtl/intra_4x4_mode_ctx_pkg.sv
// intra_4x4_mode_ctx shared package: mode constants, index sets,
// FSM encoding, syntax bundle and nibble helpers.
package intra_4x4_mode_ctx_pkg;

  localparam logic [3:0]  I4_MODE_DC  = 4'd2;
  localparam logic [3:0]  I4_MODE_NA  = 4'd15;
  localparam logic [3:0]  I4_MODE_MAX = 4'd8;
  localparam logic [15:0] I4_DC_ROW   = {4{I4_MODE_DC}};

  localparam logic [15:0] RCOL_IDX = {4'd5, 4'd7, 4'd13, 4'd15};
  localparam logic [15:0] BROW_IDX = {4'd10, 4'd11, 4'd14, 4'd15};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] blk;
    logic       flag;
    logic [2:0] rem;
  } syn_t;

  function automatic logic [5:0] nib_lsb(input logic [3:0] b);
    nib_lsb = {~b, 2'b00};
  endfunction

  function automatic logic [3:0] nib_at(
    input logic [63:0] m,
    input logic [3:0]  b
  );
    logic [5:0] lsb;
    lsb = nib_lsb(b);
    nib_at = m[lsb +: 4];
  endfunction

  function automatic logic [15:0] gather(
    input logic [63:0] m,
    input logic [15:0] idx
  );
    gather = {nib_at(m, idx[15:12]),
              nib_at(m, idx[11:8]),
              nib_at(m, idx[7:4]),
              nib_at(m, idx[3:0])};
  endfunction

  function automatic logic [2:0] rem_of(
    input logic [3:0] mode,
    input logic [3:0] pred
  );
    logic [3:0] dec;
    dec = mode - 4'd1;
    rem_of = (mode < pred) ? mode[2:0] : dec[2:0];
  endfunction

endpackage

// File: rtl/intra_4x4_mode_ctx_if.sv
// intra_4x4_mode_ctx bus: MB control, best-mode and syntax
// handshakes, and the pred-gen context bus.
interface intra_4x4_mode_ctx_if #(
  parameter int MB_X_W = 8,
  parameter int MB_Y_W = 8
);
  logic              mb_start;
  logic              mb_rdy;
  logic              mb_i4x4;
  logic [MB_X_W-1:0] mb_x_in;
  logic [MB_Y_W-1:0] mb_y_in;
  logic              mode_valid;
  logic              mode_ready;
  logic [3:0]        mode_in;
  logic [MB_X_W-1:0] pg_mb_x;
  logic [MB_Y_W-1:0] pg_mb_y;
  logic [3:0]        pg_blk4x4_num;
  logic [63:0]       pg_bm_c;
  logic [15:0]       pg_bm_l;
  logic [15:0]       pg_bm_t;
  logic [3:0]        pg_mode_pred;
  logic              syn_valid;
  logic              syn_ready;
  logic [3:0]        syn_blk;
  logic              syn_flag;
  logic [2:0]        syn_rem;
  logic              mb_done;
  logic              err;

  modport master (
    output mb_start, mb_i4x4, mb_x_in, mb_y_in,
    output mode_valid, mode_in, pg_mode_pred, syn_ready,
    input  mb_rdy, mode_ready,
    input  pg_mb_x, pg_mb_y, pg_blk4x4_num,
    input  pg_bm_c, pg_bm_l, pg_bm_t,
    input  syn_valid, syn_blk, syn_flag, syn_rem,
    input  mb_done, err
  );

  modport slave (
    input  mb_start, mb_i4x4, mb_x_in, mb_y_in,
    input  mode_valid, mode_in, pg_mode_pred, syn_ready,
    output mb_rdy, mode_ready,
    output pg_mb_x, pg_mb_y, pg_blk4x4_num,
    output pg_bm_c, pg_bm_l, pg_bm_t,
    output syn_valid, syn_blk, syn_flag, syn_rem,
    output mb_done, err
  );
endinterface

// File: rtl/intra_4x4_mode_ctx_top_line_buf.sv
// intra_4x4_top_line_buf: single-port top-row mode RAM, 1-cycle
// read; out-of-range addresses read DC and never write.
module intra_4x4_top_line_buf
  import intra_4x4_mode_ctx_pkg::*;
#(
  parameter int MAX_MB_X = 120,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);
  localparam int IW = (MAX_MB_X > 1) ? $clog2(MAX_MB_X) : 1;
  localparam logic [AW:0] LIM = (AW+1)'(MAX_MB_X);

  logic [15:0]   r_mem [MAX_MB_X];
  logic [15:0]   r_rdata;
  logic          w_in_range;
  logic [IW-1:0] w_idx;

  assign w_in_range = {1'b0, i_addr} < LIM;
  assign w_idx      = i_addr[IW-1:0];
  assign o_rdata    = r_rdata;

  // storage write, guarded against columns past the picture edge
  always_ff @(posedge clk) begin
    if (i_we && w_in_range)
      r_mem[w_idx] <= i_wdata;
  end

  // registered read; outside the picture behaves like DC neighbours
  always_ff @(posedge clk) begin
    r_rdata <= w_in_range ? r_mem[w_idx] : I4_DC_ROW;
  end
endmodule

// File: rtl/intra_4x4_mode_ctx.sv
// intra_4x4_mode_ctx: intra4x4 mode context + mode syntax gen.
// Optional mode range check: define INTRA4X4_MODE_CHK_EN.
module intra_4x4_mode_ctx
  import intra_4x4_mode_ctx_pkg::*;
#(
  parameter int MB_X_W   = 8,
  parameter int MB_Y_W   = 8,
  parameter int MAX_MB_X = 120
) (
  input logic clk,
  input logic rst_n,
  intra_4x4_mode_ctx_if.slave bus
);
  state_t            r_state;
  logic              r_mb_rdy;
  logic              r_i4x4;
  logic              r_mb_done;
  logic [MB_X_W-1:0] r_mb_x;
  logic [MB_Y_W-1:0] r_mb_y;
  logic [3:0]        r_blk;
  logic [63:0]       r_bm_c;
  logic [15:0]       r_bm_l;
  logic [15:0]       r_bm_t;
  logic              r_syn_valid;
  syn_t              r_syn;

  logic              w_mode_ready;
  logic              w_xfer;
  logic [3:0]        w_mode;
  logic [5:0]        w_lsb;
  logic              w_lb_we;
  logic [MB_X_W-1:0] w_lb_addr;
  logic [15:0]       w_lb_rdata;
  logic [15:0]       w_top_wb;
  logic [15:0]       w_left_wb;

  assign w_mode_ready = (r_state == ST_RUN) &&
                        (!r_syn_valid || bus.syn_ready);
  assign w_xfer = bus.mode_valid && w_mode_ready;
  assign w_lsb  = nib_lsb(r_blk);

`ifdef INTRA4X4_MODE_CHK_EN
  logic w_bad;
  logic r_err;

  assign w_bad  = bus.mode_in > I4_MODE_MAX;
  assign w_mode = w_bad ? I4_MODE_DC : bus.mode_in;
  assign bus.err = r_err;

  // sticky flag for any accepted out-of-range mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_xfer && w_bad)
      r_err <= 1'b1;
  end
`else
  assign w_mode  = bus.mode_in;
  assign bus.err = 1'b0;
`endif

  assign w_top_wb  = r_i4x4 ? gather(r_bm_c, BROW_IDX)
                            : I4_DC_ROW;
  assign w_left_wb = r_i4x4 ? gather(r_bm_c, RCOL_IDX)
                            : I4_DC_ROW;

  assign w_lb_we   = (r_state == ST_WB);
  assign w_lb_addr = w_lb_we ? r_mb_x : bus.mb_x_in;

  intra_4x4_top_line_buf #(
    .MAX_MB_X (MAX_MB_X),
    .AW       (MB_X_W)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_lb_we),
    .i_addr  (w_lb_addr),
    .i_wdata (w_top_wb),
    .o_rdata (w_lb_rdata)
  );

  // MB sequencer: start, top fetch, block collection, write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mb_rdy  <= 1'b1;
      r_i4x4    <= 1'b0;
      r_mb_done <= 1'b0;
      r_mb_x    <= '0;
      r_mb_y    <= '0;
      r_blk     <= '0;
      r_bm_c    <= '0;
      r_bm_t    <= '0;
      r_bm_l    <= I4_DC_ROW;
    end else begin
      r_mb_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.mb_start) begin
            r_mb_x   <= bus.mb_x_in;
            r_mb_y   <= bus.mb_y_in;
            r_i4x4   <= bus.mb_i4x4;
            r_bm_c   <= '0;
            r_mb_rdy <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_bm_t  <= w_lb_rdata;
          r_blk   <= '0;
          r_state <= r_i4x4 ? ST_RUN : ST_WB;
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_bm_c[w_lsb +: 4] <= w_mode;
            r_blk <= r_blk + 4'd1;
            if (r_blk == 4'd15)
              r_state <= ST_WB;
          end
        end
        ST_WB: begin
          r_bm_l    <= w_left_wb;
          r_mb_done <= 1'b1;
          r_mb_rdy  <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // syntax output register; a new transfer overrides the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_syn_valid <= 1'b0;
      r_syn       <= '0;
    end else if (w_xfer) begin
      r_syn_valid <= 1'b1;
      r_syn.blk   <= r_blk;
      r_syn.flag  <= (w_mode == bus.pg_mode_pred);
      r_syn.rem   <= rem_of(w_mode, bus.pg_mode_pred);
    end else if (bus.syn_ready) begin
      r_syn_valid <= 1'b0;
    end
  end

  assign bus.mb_rdy        = r_mb_rdy;
  assign bus.mode_ready    = w_mode_ready;
  assign bus.pg_mb_x       = r_mb_x;
  assign bus.pg_mb_y       = r_mb_y;
  assign bus.pg_blk4x4_num = r_blk;
  assign bus.pg_bm_c       = r_bm_c;
  assign bus.pg_bm_l       = r_bm_l;
  assign bus.pg_bm_t       = r_bm_t;
  assign bus.syn_valid     = r_syn_valid;
  assign bus.syn_blk       = r_syn.blk;
  assign bus.syn_flag      = r_syn.flag;
  assign bus.syn_rem       = r_syn.rem;
  assign bus.mb_done       = r_mb_done;
endmodule
